// File: rtl/mme_tile_engine_if.sv
// Stream bundle of the MME tile engine: A column and B row inputs, C row output.
// The engine connects through slave; the feeding/draining side uses master.
interface mme_tile_engine_if #(
    parameter int unsigned P      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OUT_W  = 32
) ();
    logic                a_valid;
    logic                a_ready;
    logic [P*DATA_W-1:0] a_data;
    logic                b_valid;
    logic                b_ready;
    logic [P*DATA_W-1:0] b_data;
    logic                c_valid;
    logic                c_ready;
    logic [P*OUT_W-1:0]  c_data;
    logic                c_last;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, c_ready,
        output a_ready, b_ready, c_valid, c_data, c_last
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, c_ready,
        input  a_ready, b_ready, c_valid, c_data, c_last
    );
endinterface

// File: rtl/mme_tile_engine.sv
// P x P outer-product matrix engine: C (+)= A x B over K steps, C streamed out row by row.
// Two-stage datapath (multiply, then accumulate) followed by a fixed 2-cycle drain.
module mme_tile_engine #(
    parameter int unsigned P      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 72,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned K_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_W-1:0]     cfg_k,
    input  logic               cfg_acc,
    input  logic               cfg_signed,
    input  logic               cfg_sat,
    mme_tile_engine_if.slave   s,
    output logic               busy,
    output logic               done
);
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned RW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUTPUT} state_t;

    state_t           state, state_nxt;
    logic [K_W-1:0]   step, k_lat;
    logic             sgn, sat, drain_cnt, prod_vld;
    logic             fire, out_phase, row_hs, last_hs;
    logic [RW-1:0]    row;
    logic [PW-1:0]    prod [P][P];
    logic [ACC_W-1:0] acc  [P][P];

    function automatic logic [PW-1:0] mul(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic s_en);
        logic signed [PW+1:0] x, y, p;
        x = $signed({{(DATA_W+2){s_en & a[DATA_W-1]}}, a});
        y = $signed({{(DATA_W+2){s_en & b[DATA_W-1]}}, b});
        p = x * y;
        return p[PW-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] ext(input logic [PW-1:0] p, input logic s_en);
        logic [ACC_W+PW-1:0] w;
        w = {{ACC_W{s_en & p[PW-1]}}, p};
        return w[ACC_W-1:0];
    endfunction

    // Saturation checks that the bits above the output field are pure sign (or zero) extension.
    function automatic logic [OUT_W-1:0] fmt(input logic [ACC_W-1:0] v,
                                             input logic s_en, input logic sat_en);
        logic [ACC_W-1:0] hi;
        fmt = v[OUT_W-1:0];
        if (sat_en) begin
            if (s_en) begin
                hi = $unsigned($signed(v) >>> (OUT_W - 1));
                if (hi != '0 && hi != '1)
                    fmt = v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                hi = v >> OUT_W;
                if (hi != '0)
                    fmt = '1;
            end
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (cfg_k == '0) ? DRAIN : COMPUTE;
            COMPUTE: if (fire && (step + 1'b1) == k_lat) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = OUTPUT;
            OUTPUT:  if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire      = (state == COMPUTE) && s.a_valid && s.b_valid && (step < k_lat);
        out_phase = (state == OUTPUT);
        s.a_ready = fire;
        s.b_ready = fire;
        busy      = (state != IDLE);
        s.c_valid = out_phase;
        s.c_last  = out_phase && (row == RW'(P - 1));
        row_hs    = out_phase && s.c_ready;
        last_hs   = row_hs && (row == RW'(P - 1));
        s.c_data  = '0;
        if (out_phase)
            for (int unsigned j = 0; j < P; j++)
                s.c_data[j*OUT_W +: OUT_W] = fmt(acc[row][j], sgn, sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step      <= '0;
            k_lat     <= '0;
            sgn       <= 1'b0;
            sat       <= 1'b0;
            drain_cnt <= 1'b0;
            prod_vld  <= 1'b0;
            row       <= '0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < P; i++)
                for (int unsigned j = 0; j < P; j++) begin
                    prod[i][j] <= '0;
                    acc[i][j]  <= '0;
                end
        end else begin
            done     <= last_hs;
            prod_vld <= fire;
            for (int unsigned i = 0; i < P; i++)
                for (int unsigned j = 0; j < P; j++) begin
                    if (fire)
                        prod[i][j] <= mul(s.a_data[i*DATA_W +: DATA_W],
                                          s.b_data[j*DATA_W +: DATA_W], sgn);
                    if (prod_vld)
                        acc[i][j] <= acc[i][j] + ext(prod[i][j], sgn);
                end
            if (fire)
                step <= step + 1'b1;
            if (state == DRAIN)
                drain_cnt <= ~drain_cnt;
            if (row_hs)
                row <= row + 1'b1;
            if (state == IDLE && start) begin
                k_lat     <= cfg_k;
                sgn       <= cfg_signed;
                sat       <= cfg_sat;
                step      <= '0;
                row       <= '0;
                drain_cnt <= 1'b0;
                if (!cfg_acc)
                    for (int unsigned i = 0; i < P; i++)
                        for (int unsigned j = 0; j < P; j++)
                            acc[i][j] <= '0;
            end
        end
    end
endmodule

// File: doc/mme_tile_engine.md
Name: mme_tile_engine

Overview:
- Parametrised compute core for the next-generation matrix multiplication engine. It computes C(PxP) = A(PxK) x B(KxP) by K outer-product steps. Optional accumulate mode gives C += A x B.
- Sits between the MME DMA/read path and the C write-back path.
- Consumes one A column (column-major fetch) and one B row (row-major fetch) per step.
- Emits C row by row over a valid/ready stream.
- Generalises the fixed 4-wide engine in tile size, operand width, signedness, accumulation and output saturation.

Parameters:
- P, 4, tile dimension (P x P accumulators, P*P multipliers), >=2
- DATA_W, 32, operand element width
- ACC_W, 72, accumulator width; must be >= 2*DATA_W
- OUT_W, 32, C element output width; must be <= ACC_W
- K_W, 16, width of cfg_k (max K = 2^K_W - 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle command pulse, sampled only in IDLE
- cfg_k  in  K_W  inner dimension K, latched at start
- cfg_acc  in  1  1 = keep accumulators (C += AxB); 0 = clear at start; latched
- cfg_signed  in  1  1 = operands two's complement; 0 = unsigned; latched
- cfg_sat  in  1  1 = saturate output to OUT_W; 0 = truncate to low OUT_W bits; latched
- a_valid  in  1  A column valid
- a_ready  out  1  A column accepted
- a_data  in  P*DATA_W  element i = A[i][k] at bits [i*DATA_W +: DATA_W]
- b_valid  in  1  B row valid
- b_ready  out  1  B row accepted
- b_data  in  P*DATA_W  element j = B[k][j] at bits [j*DATA_W +: DATA_W]
- c_valid  out  1  C row valid
- c_ready  in  1  C row accepted
- c_data  out  P*OUT_W  element j = C[r][j]
- c_last  out  1  high with row P-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final C row handshake

Behaviour:
- Reset values: a_ready=0, b_ready=0, c_valid=0, c_last=0, c_data=0, busy=0, done=0. All accumulators, counters and pipeline registers are 0; state = IDLE. Reset mid-operation aborts immediately and discards partial sums.
- States: IDLE -> COMPUTE -> DRAIN -> OUTPUT -> IDLE.
- IDLE:
  - start=1 latches cfg_*; accumulators are cleared if cfg_acc=0.
  - Goes to COMPUTE, or to DRAIN if cfg_k=0 (C = existing accumulators).
  - start in any other state is ignored.
- COMPUTE:
  - Joint handshake: fire = a_valid & b_valid & (step < K); a_ready = b_ready = fire. Neither stream is consumed alone.
  - Stage 1 (fire cycle+1): products p[i][j] = a_i * b_j, 2*DATA_W wide. Extension follows latched cfg_signed.
  - Stage 2 (+2): acc[i][j] += extended p[i][j], wrapping mod 2^ACC_W.
  - Bubbles are allowed; step increments per fire. After the K-th fire, go to DRAIN.
- DRAIN: fixed 2 cycles so the last product is accumulated, then OUTPUT with row r=0.
- OUTPUT:
  - c_valid=1; c_data = row r formatted; c_last = (r==P-1).
  - c_data and c_last stay stable while c_valid & !c_ready.
  - On each handshake r increments. On the handshake of row P-1: c_valid drops next cycle, done pulses next cycle, state returns to IDLE.
- Formatting:
  - cfg_sat=0: low OUT_W bits.
  - cfg_sat=1, signed: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - cfg_sat=1, unsigned: clamp to [0, 2^OUT_W-1].
- Accumulators are retained after done; a cfg_acc=1 command adds to them.
- First-command latency with continuously valid inputs: K fire cycles + 2 DRAIN cycles + 1 cycle to first c_valid.

Test Plan:
- P=4, K=4, unsigned, random 0..255 operands, inputs always valid, c_ready=1 -> 4 C rows equal to the software product. c_last on row 3, done 1 cycle after; busy low afterwards.
- K=16 with random a_valid/b_valid gaps and 30% c_ready stalls -> results identical to the no-stall run; c_data stable during stalls; no step consumed unless both valids are high.
- Signed, A all -1 (0xFFFFFFFF), B all 2, K=3 -> every C element = -6 (0xFFFFFFFA). Same operands unsigned with cfg_sat=1 -> every element = 0xFFFFFFFF.
- Accumulate: run K=4 (C0), then cfg_acc=1 with same operands -> C = 2*C0. Then cfg_acc=0, cfg_k=0 -> all four rows are 0.
- start pulsed during COMPUTE and OUTPUT -> ignored, single result set. cfg_k=0 with cfg_acc=1 -> prior accumulators output with no a/b handshakes.
- rst asserted at step 2 of K=8 -> outputs at reset values immediately. New K=4 cfg_acc=1 command then yields the plain product (no residue from the aborted run).
